clock_monitor: RTL and testbench

CLOCK_MONITOR -- requirements
Module: clock_monitor

---
 rtl/clock_mon_pkg.sv | 25 ++
 rtl/clock_monitor_edge_sync.sv | 29 ++
 rtl/clock_monitor.sv | 167 ++++++++++++++++
 tb/tb_clock_monitor.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_mon_pkg.sv
// rtl/clock_mon_pkg.sv - shared state enum, default constants and window helper for clock_monitor
package clock_mon_pkg;

   typedef enum logic {
      WAIT_GATE = 1'b0,
      MEASURE   = 1'b1
   } mon_state_e;

   localparam logic [15:0] EXP_COUNT_DEF    = 16'd20000;
   localparam logic [15:0] TOL_DEF          = 16'd16;
   localparam logic [16:0] GATE_TIMEOUT_DEF = 17'd72000;
   localparam logic [3:0]  EDGE_TIMEOUT_DEF = 4'd8;

   // Lower bound clamps at zero so a tolerance wider than the target never wraps.
   function automatic logic in_window(input logic [15:0] cnt,
                                      input logic [15:0] exp_cnt,
                                      input logic [15:0] tol);
      logic [16:0] lo;
      logic [16:0] hi;
      lo = (exp_cnt >= tol) ? ({1'b0, exp_cnt} - {1'b0, tol}) : 17'd0;
      hi = {1'b0, exp_cnt} + {1'b0, tol};
      return ({1'b0, cnt} >= lo) && ({1'b0, cnt} <= hi);
   endfunction

endpackage

// File: rtl/clock_monitor_edge_sync.sv
// rtl/clock_monitor_edge_sync.sv - 2-FF synchronizer plus history FF with rise and any-edge detect
module edge_sync (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic sig_i,
   output logic rise_o,
   output logic edge_o
);

   logic meta_q;
   logic sync_q;
   logic hist_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         hist_q <= 1'b0;
      end else begin
         meta_q <= sig_i;
         sync_q <= meta_q;
         hist_q <= sync_q;
      end
   end

   assign rise_o = sync_q & ~hist_q;
   assign edge_o = sync_q ^ hist_q;

endmodule

// File: rtl/clock_monitor.sv
// rtl/clock_monitor.sv - counts clk_4mhz edges per clk_5ms half-period, flags lost clocks
// Define CLOCK_MONITOR_STICKY_EN to hold clk4_lost/gate_lost until fault_clr.
module clock_monitor
   import clock_mon_pkg::*;
#(
   parameter logic [15:0] EXP_COUNT    = EXP_COUNT_DEF,
   parameter logic [15:0] TOL          = TOL_DEF,
   parameter logic [16:0] GATE_TIMEOUT = GATE_TIMEOUT_DEF,
   parameter logic [3:0]  EDGE_TIMEOUT = EDGE_TIMEOUT_DEF
) (
   input  logic        clk_12mhz,
   input  logic        reset_n,
   input  logic        clk_4mhz,
   input  logic        clk_5ms,
   input  logic        fault_clr,
   output logic [15:0] meas_count,
   output logic        meas_valid,
   output logic        freq_ok,
   output logic        clk4_lost,
   output logic        gate_lost
);

   mon_state_e  state_q;
   logic [15:0] cnt_q;
   logic [15:0] cnt_inc;
   logic [15:0] meas_count_q;
   logic        meas_valid_q;
   logic        freq_ok_q;
   logic [16:0] gate_wd_q;
   logic [3:0]  edge_wd_q;
   logic        clk4_lost_q;
   logic        clk4_lost_d;
   logic        gate_lost_q;
   logic        gate_lost_d;

   logic        clk4_rise;
   logic        gate_edge;
   logic        gate_to_hit;
   logic        edge_to_hit;
   logic        unused_clk4_edge;
   logic        unused_gate_rise;

   edge_sync u_clk4_sync (
      .clk_i  (clk_12mhz),
      .rst_ni (reset_n),
      .sig_i  (clk_4mhz),
      .rise_o (clk4_rise),
      .edge_o (unused_clk4_edge)
   );

   edge_sync u_gate_sync (
      .clk_i  (clk_12mhz),
      .rst_ni (reset_n),
      .sig_i  (clk_5ms),
      .rise_o (unused_gate_rise),
      .edge_o (gate_edge)
   );

   assign cnt_inc = (clk4_rise && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;

   // Watchdogs park at their limit, so each fires exactly once per outage.
   assign gate_to_hit = !gate_edge && ((gate_wd_q + 17'd1) == GATE_TIMEOUT);
   assign edge_to_hit = (state_q == MEASURE) && !clk4_rise &&
                        ((edge_wd_q + 4'd1) == EDGE_TIMEOUT);

   always_ff @(posedge clk_12mhz or negedge reset_n) begin
      if (!reset_n) begin
         gate_wd_q <= '0;
         edge_wd_q <= '0;
      end else begin
         if (gate_edge) begin
            gate_wd_q <= '0;
         end else if (gate_wd_q != GATE_TIMEOUT) begin
            gate_wd_q <= gate_wd_q + 17'd1;
         end

         if ((state_q != MEASURE) || clk4_rise) begin
            edge_wd_q <= '0;
         end else if (edge_wd_q != EDGE_TIMEOUT) begin
            edge_wd_q <= edge_wd_q + 4'd1;
         end
      end
   end

`ifdef CLOCK_MONITOR_STICKY_EN
   always_comb begin
      clk4_lost_d = clk4_lost_q;
      gate_lost_d = gate_lost_q;
      if (fault_clr) begin
         clk4_lost_d = 1'b0;
         gate_lost_d = 1'b0;
      end
      if (edge_to_hit) clk4_lost_d = 1'b1;
      if (gate_to_hit) gate_lost_d = 1'b1;
   end
`else
   always_comb begin
      clk4_lost_d = clk4_lost_q;
      gate_lost_d = gate_lost_q;
      if (clk4_rise) clk4_lost_d = 1'b0;
      if (gate_edge) gate_lost_d = 1'b0;
      if (edge_to_hit) clk4_lost_d = 1'b1;
      if (gate_to_hit) gate_lost_d = 1'b1;
   end

   logic unused_fault_clr;
   assign unused_fault_clr = fault_clr;
`endif

   always_ff @(posedge clk_12mhz or negedge reset_n) begin
      if (!reset_n) begin
         clk4_lost_q <= 1'b0;
         gate_lost_q <= 1'b0;
      end else begin
         clk4_lost_q <= clk4_lost_d;
         gate_lost_q <= gate_lost_d;
      end
   end

   always_ff @(posedge clk_12mhz or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= WAIT_GATE;
         cnt_q        <= '0;
         meas_count_q <= '0;
         meas_valid_q <= 1'b0;
         freq_ok_q    <= 1'b0;
      end else begin
         meas_valid_q <= 1'b0;
         case (state_q)
            WAIT_GATE: begin
               cnt_q <= '0;
               if (gate_edge) begin
                  state_q <= MEASURE;
               end
            end
            MEASURE: begin
               if (gate_to_hit) begin
                  state_q <= WAIT_GATE;
                  cnt_q   <= '0;
               end else if (gate_edge) begin
                  // cnt_inc folds in a clk_4mhz edge landing on the gate edge itself.
                  meas_count_q <= cnt_inc;
                  meas_valid_q <= 1'b1;
                  freq_ok_q    <= in_window(cnt_inc, EXP_COUNT, TOL);
                  cnt_q        <= '0;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            default: begin
               state_q <= WAIT_GATE;
               cnt_q   <= '0;
            end
         endcase
         if (gate_to_hit || edge_to_hit) begin
            freq_ok_q <= 1'b0;
         end
      end
   end

   assign meas_count = meas_count_q;
   assign meas_valid = meas_valid_q;
   assign freq_ok    = freq_ok_q;
   assign clk4_lost  = clk4_lost_q;
   assign gate_lost  = gate_lost_q;

endmodule

// File: tb/tb_clock_monitor.sv
// tb/tb_clock_monitor.sv - randomized scoreboard bench for clock_monitor with scaled-down parameters
module tb_clock_monitor;

   localparam logic [15:0] P_EXP = 16'd20;
   localparam logic [15:0] P_TOL = 16'd2;
   localparam logic [16:0] P_GTO = 17'd300;
   localparam logic [3:0]  P_ETO = 4'd8;
`ifdef CLOCK_MONITOR_STICKY_EN
   localparam logic STICKY = 1'b1;
`else
   localparam logic STICKY = 1'b0;
`endif

   logic        clk_12mhz;
   logic        reset_n;
   logic        clk_4mhz;
   logic        clk_5ms;
   logic        fault_clr;
   logic [15:0] meas_count;
   logic        meas_valid;
   logic        freq_ok;
   logic        clk4_lost;
   logic        gate_lost;

   typedef struct {
      logic [15:0] cnt;
      logic        ok;
   } exp_t;

   exp_t sb_q[$];
   int   total;
   int   bad;

   // reference model state, advanced once per driven cycle
   int   m_cnt;
   bit   m_meas;
   bit   m_prev_c4;
   bit   m_prev_g;
   int   m_idle;
   bit   g_lvl;
   int   c4_ph;

   clock_monitor #(
      .EXP_COUNT    (P_EXP),
      .TOL          (P_TOL),
      .GATE_TIMEOUT (P_GTO),
      .EDGE_TIMEOUT (P_ETO)
   ) dut (
      .clk_12mhz  (clk_12mhz),
      .reset_n    (reset_n),
      .clk_4mhz   (clk_4mhz),
      .clk_5ms    (clk_5ms),
      .fault_clr  (fault_clr),
      .meas_count (meas_count),
      .meas_valid (meas_valid),
      .freq_ok    (freq_ok),
      .clk4_lost  (clk4_lost),
      .gate_lost  (gate_lost)
   );

   initial clk_12mhz = 1'b0;
   always #5 clk_12mhz = ~clk_12mhz;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic bit in_rng(input int c);
      int lo;
      lo = int'(P_EXP) - int'(P_TOL);
      if (lo < 0) lo = 0;
      return (c >= lo) && (c <= int'(P_EXP) + int'(P_TOL));
   endfunction

   function automatic void model_reset();
      m_cnt     = 0;
      m_meas    = 1'b0;
      m_prev_c4 = 1'b0;
      m_prev_g  = 1'b0;
      m_idle    = 0;
   endfunction

   task automatic drive(input bit c4, input bit g);
      exp_t e;
      @(negedge clk_12mhz);
      clk_4mhz = c4;
      clk_5ms  = g;
      if (c4 && !m_prev_c4 && m_cnt < 65535) m_cnt++;
      if (g != m_prev_g) begin
         if (m_meas) begin
            e.cnt = 16'(m_cnt);
            e.ok  = in_rng(m_cnt);
            sb_q.push_back(e);
         end
         m_meas = 1'b1;
         m_cnt  = 0;
         m_idle = 0;
      end else begin
         m_idle++;
         if (m_idle >= int'(P_GTO)) m_meas = 1'b0;
      end
      m_prev_c4 = c4;
      m_prev_g  = g;
   endtask

   task automatic c4_run(input int k);
      for (int i = 0; i < k; i++) begin
         c4_ph = (c4_ph + 1) % 3;
         drive(c4_ph == 0, g_lvl);
      end
   endtask

   task automatic run_window(input int n, input bit coincide);
      int lo;
      int hi;
      for (int i = 0; i < n; i++) begin
         lo = int'($urandom_range(1, 2));
         hi = int'($urandom_range(1, 2));
         repeat (lo) drive(1'b0, g_lvl);
         if (coincide && i == n - 1) g_lvl = ~g_lvl;
         drive(1'b1, g_lvl);
         repeat (hi - 1) drive(1'b1, g_lvl);
      end
      if (!coincide) begin
         g_lvl = ~g_lvl;
         drive(1'b0, g_lvl);
      end
   endtask

   task automatic rand_window();
      int n;
      case ($urandom_range(0, 5))
         0: n = 17;
         1: n = 18;
         2: n = 20;
         3: n = 22;
         4: n = 23;
         default: n = int'($urandom_range(1, 40));
      endcase
      run_window(n, $urandom_range(0, 1) == 1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_meas_count"}, 32'(meas_count), 32'd0);
      check({tag, "_meas_valid"}, 32'(meas_valid), 32'd0);
      check({tag, "_freq_ok"},    32'(freq_ok),    32'd0);
      check({tag, "_clk4_lost"},  32'(clk4_lost),  32'd0);
      check({tag, "_gate_lost"},  32'(gate_lost),  32'd0);
   endtask

   // scoreboard monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge clk_12mhz);
         #1;
         if (meas_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_meas_valid: got meas_count=%0d expected no measurement", meas_count);
            end else begin
               e = sb_q.pop_front();
               check("meas_count", 32'(meas_count), 32'(e.cnt));
               check("freq_ok",    32'(freq_ok),    32'(e.ok));
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL bench_timeout: got no finish expected finish within time limit");
      $fatal(1, "bench stalled");
   end

   initial begin
      total     = 0;
      bad       = 0;
      g_lvl     = 1'b0;
      c4_ph     = 0;
      reset_n   = 1'b0;
      fault_clr = 1'b0;
      clk_4mhz  = 1'b0;
      clk_5ms   = 1'b0;
      model_reset();
      repeat (3) @(negedge clk_12mhz);
      check_all_zero("reset");
      reset_n = 1'b1;

      run_window(5, 1'b0);
      repeat (24) rand_window();

      // gate loss: hold clk_5ms while clk_4mhz keeps running
      run_window(20, 1'b0);
      c4_run(400);
      check("gate_lost_set", 32'(gate_lost), 32'd1);
      check("gate_lost_freq_ok", 32'(freq_ok), 32'd0);
      fault_clr = 1'b1;
      c4_run(1);
      fault_clr = 1'b0;
      c4_run(4);
      check("gate_lost_after_fault_clr", 32'(gate_lost), 32'(!STICKY));
      run_window(20, 1'b0);
      c4_run(9);
      check("gate_lost_after_edge", 32'(gate_lost), 32'd0);
      run_window(20, 1'b1);

      // clk_4mhz loss in the middle of a measurement
      c4_run(30);
      repeat (20) drive(1'b0, g_lvl);
      check("clk4_lost_set", 32'(clk4_lost), 32'd1);
      check("clk4_lost_freq_ok", 32'(freq_ok), 32'd0);
      c4_run(9);
      check("clk4_lost_after_edge", 32'(clk4_lost), 32'(STICKY));
      fault_clr = 1'b1;
      c4_run(1);
      fault_clr = 1'b0;
      c4_run(8);
      check("clk4_lost_after_fault_clr", 32'(clk4_lost), 32'd0);
      run_window(5, 1'b0);

      repeat (6) rand_window();

      // reset partway through a gate period
      c4_run(20);
      @(negedge clk_12mhz);
      reset_n = 1'b0;
      #1;
      check_all_zero("midreset");
      model_reset();
      repeat (3) @(negedge clk_12mhz);
      reset_n = 1'b1;
      run_window(10, 1'b0);
      run_window(20, 1'b1);
      repeat (8) rand_window();

      c4_run(12);
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
